// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, address bit positions, mode-register helpers
// and the init sequencer state type. Also used by the refresh and read/write controllers.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef logic [3:0] sdram_cmd_t;

    localparam sdram_cmd_t CMD_NOP  = 4'b0111;
    localparam sdram_cmd_t CMD_PRE  = 4'b0010;
    localparam sdram_cmd_t CMD_AREF = 4'b0001;
    localparam sdram_cmd_t CMD_MRS  = 4'b0000;

    // A10 high during PRECHARGE selects all banks
    localparam int A10_IDX = 10;

    localparam logic [2:0] BL_1 = 3'd0;
    localparam logic [2:0] BL_2 = 3'd1;
    localparam logic [2:0] BL_4 = 3'd2;
    localparam logic [2:0] BL_8 = 3'd3;
    localparam logic       BT_SEQ   = 1'b0;
    localparam logic       BT_INTLV = 1'b1;

    typedef enum logic [2:0] {
        ST_WAIT_PU,
        ST_PRE,
        ST_W_RP,
        ST_AREF,
        ST_W_RFC,
        ST_MRS,
        ST_W_MRD,
        ST_DONE
    } init_state_t;

    // Standard JEDEC mode register layout: [9] write burst, [6:4] CL, [3] BT, [2:0] BL
    function automatic logic [11:0] mode_word(input logic [2:0] cas_lat,
                                              input logic       burst_type,
                                              input logic [2:0] burst_len,
                                              input logic       single_wr);
        return {2'b00, single_wr, 2'b00, cas_lat, burst_type, burst_len};
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_ctrl_if.sv
// Bus between the init sequencer (master) and the SDRAM command arbiter (slave).
interface sdram_init_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int BA_W   = 2
);
    logic                   init_req;
    sdram_pkg::sdram_cmd_t  cmd;
    logic [ADDR_W-1:0]      sdram_addr;
    logic [BA_W-1:0]        sdram_ba;
    logic                   init_busy;
    logic                   init_done;
    logic                   init_done_p;

    modport master (
        input  init_req,
        output cmd, sdram_addr, sdram_ba, init_busy, init_done, init_done_p
    );

    modport slave (
        output init_req,
        input  cmd, sdram_addr, sdram_ba, init_busy, init_done, init_done_p
    );
endinterface

// File: rtl/sdram_wait_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module sdram_wait_cnt #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up / re-init sequencer: power-up wait, PRECHARGE-ALL, AREF_NUM x AUTO-REFRESH,
// LOAD MODE REGISTER, then hands the bus to the arbiter and waits for a re-init request.
module sdram_init_ctrl
    import sdram_pkg::*;
#(
    parameter int          T_POWERUP = 10000,
    parameter int          T_RP      = 2,
    parameter int          T_RFC     = 7,
    parameter int          T_MRD     = 2,
    parameter int          AREF_NUM  = 2,
    parameter int          ADDR_W    = 12,
    parameter int          BA_W      = 2,
    parameter logic [31:0] MODE_VAL  = 32'(mode_word(3'd3, BT_SEQ, BL_4, 1'b0))
) (
    input  logic              clk,
    input  logic              rstn,
    sdram_init_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(max4(T_POWERUP, T_RFC, T_RP, T_MRD) + 1);
    localparam int REF_W = $clog2(AREF_NUM + 1);

    localparam logic [CNT_W-1:0]  PU_LOAD   = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0]  RP_LOAD   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0]  RFC_LOAD  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0]  MRD_LOAD  = CNT_W'(T_MRD - 1);
    localparam logic [REF_W-1:0]  AREF_LIM  = REF_W'(AREF_NUM);
    localparam logic [ADDR_W-1:0] MODE_ADDR = ADDR_W'(MODE_VAL);

    if (T_POWERUP < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1) begin : g_bad_timing
        $error("sdram_init_ctrl: every T_* parameter must be at least 1");
    end
    if (AREF_NUM < 1) begin : g_bad_aref
        $error("sdram_init_ctrl: AREF_NUM must be at least 1");
    end
    if (ADDR_W < 11) begin : g_bad_addr
        $error("sdram_init_ctrl: ADDR_W must be at least 11 to reach A10");
    end

    init_state_t       state_q, state_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    sdram_cmd_t        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              done_p_q, done_p_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_zero;
    logic              reinit;

    // The reset value of the counter is the power-up wait, so WAIT_PU needs no explicit load
    sdram_wait_cnt #(
        .W       (CNT_W),
        .RST_VAL (PU_LOAD)
    ) u_wait_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // A request only counts once init_done is visible to the arbiter
    assign reinit = done_q && bus.init_req;

    always_comb begin
        state_d      = state_q;
        ref_cnt_d    = ref_cnt_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        unique case (state_q)
            ST_WAIT_PU: begin
                if (cnt_zero) begin
                    state_d   = ST_PRE;
                    ref_cnt_d = '0;
                end
            end
            ST_PRE: begin
                state_d      = ST_W_RP;
                cnt_load     = 1'b1;
                cnt_load_val = RP_LOAD;
            end
            ST_W_RP: begin
                if (cnt_zero) state_d = ST_AREF;
            end
            ST_AREF: begin
                state_d      = ST_W_RFC;
                ref_cnt_d    = ref_cnt_q + REF_W'(1);
                cnt_load     = 1'b1;
                cnt_load_val = RFC_LOAD;
            end
            ST_W_RFC: begin
                if (cnt_zero) begin
                    state_d = (ref_cnt_q < AREF_LIM) ? ST_AREF : ST_MRS;
                end
            end
            ST_MRS: begin
                state_d      = ST_W_MRD;
                cnt_load     = 1'b1;
                cnt_load_val = MRD_LOAD;
            end
            ST_W_MRD: begin
                if (cnt_zero) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (reinit) begin
                    state_d   = ST_PRE;
                    ref_cnt_d = '0;
                end
            end
            default: state_d = ST_WAIT_PU;
        endcase
    end

    // Outputs are registered from the current state, so each command occupies exactly one cycle
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        unique case (state_q)
            ST_PRE: begin
                cmd_d           = CMD_PRE;
                addr_d[A10_IDX] = 1'b1;
            end
            ST_AREF: cmd_d = CMD_AREF;
            ST_MRS: begin
                cmd_d  = CMD_MRS;
                addr_d = MODE_ADDR;
            end
            default: ;
        endcase
        done_d   = (state_q == ST_DONE) && !reinit;
        busy_d   = !done_d;
        done_p_d = done_d && !done_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_WAIT_PU;
            ref_cnt_q <= '0;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            done_p_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_p_q  <= done_p_d;
        end
    end

    assign bus.cmd         = cmd_q;
    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_ba    = '0;
    assign bus.init_busy   = busy_q;
    assign bus.init_done   = done_q;
    assign bus.init_done_p = done_p_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Bench for sdram_init_ctrl: two configurations checked every cycle against a timeline model.
module tb_sdram_init_ctrl;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MRS  = 4'b0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn0, rstn1;
    logic req0, req1;

    sdram_init_ctrl_if #(.ADDR_W(12), .BA_W(2)) if0 ();
    sdram_init_ctrl_if #(.ADDR_W(12), .BA_W(2)) if1 ();

    assign if0.init_req = req0;
    assign if1.init_req = req1;

    sdram_init_ctrl #(
        .T_POWERUP(10000), .T_RP(2), .T_RFC(7), .T_MRD(2), .AREF_NUM(2),
        .ADDR_W(12), .BA_W(2), .MODE_VAL(32'h032)
    ) dut0 (.clk(clk), .rstn(rstn0), .bus(if0));

    sdram_init_ctrl #(
        .T_POWERUP(16), .T_RP(2), .T_RFC(3), .T_MRD(2), .AREF_NUM(8),
        .ADDR_W(12), .BA_W(2), .MODE_VAL(32'h032)
    ) dut1 (.clk(clk), .rstn(rstn1), .bus(if1));

    function automatic int p_tpu(input int k);   return (k == 0) ? 10000 : 16; endfunction
    function automatic int p_trp(input int k);   return (k == 0) ? 2 : 2;      endfunction
    function automatic int p_trfc(input int k);  return (k == 0) ? 7 : 3;      endfunction
    function automatic int p_tmrd(input int k);  return (k == 0) ? 2 : 2;      endfunction
    function automatic int p_naref(input int k); return (k == 0) ? 2 : 8;      endfunction

    // Cycles from the PRE command to the first cycle init_done is high
    function automatic int seq_len(input int k);
        return 1 + p_trp(k) + p_naref(k) * (1 + p_trfc(k)) + 1 + p_tmrd(k);
    endfunction

    function automatic logic [3:0] exp_cmd(input int k, input int c, input int pre);
        int off, r, step;
        off  = c - pre;
        step = 1 + p_trfc(k);
        if (off == 0) return PRE;
        r = off - 1 - p_trp(k);
        if (r >= 0 && r < p_naref(k) * step && (r % step) == 0) return AREF;
        if (r == p_naref(k) * step) return MRS;
        return NOP;
    endfunction

    // Model state: cycle index since release, cycle of the pending PRE, cycle done rises
    int cyc     [2] = '{-1, -1};
    int pre_at  [2] = '{10000, 16};
    int done_at [2] = '{10022, 54};
    bit exp_done[2] = '{1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    initial begin
        logic rs, rq;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                rs = (k == 0) ? rstn0 : rstn1;
                rq = (k == 0) ? req0 : req1;
                if (!rs) begin
                    cyc[k]      = -1;
                    pre_at[k]   = p_tpu(k);
                    done_at[k]  = p_tpu(k) + seq_len(k);
                    exp_done[k] = 1'b0;
                end else begin
                    cyc[k] = cyc[k] + 1;
                    if (exp_done[k] && rq) begin
                        exp_done[k] = 1'b0;
                        pre_at[k]   = cyc[k] + 1;
                        done_at[k]  = cyc[k] + 1 + seq_len(k);
                    end else if (cyc[k] == done_at[k]) begin
                        exp_done[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc[k], act, exp);
        end
    endtask

    initial begin
        logic        rs, bz, dn, dp;
        logic [3:0]  c_o, e_c;
        logic [11:0] a_o, e_a;
        logic [1:0]  b_o;
        bit          prev_nn [2];
        int          aref_seen [2];
        prev_nn   = '{1'b0, 1'b0};
        aref_seen = '{0, 0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rs  = (k == 0) ? rstn0 : rstn1;
                c_o = (k == 0) ? if0.cmd : if1.cmd;
                a_o = (k == 0) ? if0.sdram_addr : if1.sdram_addr;
                b_o = (k == 0) ? if0.sdram_ba : if1.sdram_ba;
                bz  = (k == 0) ? if0.init_busy : if1.init_busy;
                dn  = (k == 0) ? if0.init_done : if1.init_done;
                dp  = (k == 0) ? if0.init_done_p : if1.init_done_p;
                chk("ba_zero", k, 32'(b_o), 32'd0);
                if (!rs || cyc[k] < 0) begin
                    chk("reset_vals", k, 32'({c_o, a_o, bz, dn, dp}), 32'({NOP, 12'h000, 3'b100}));
                    prev_nn[k]   = 1'b0;
                    aref_seen[k] = 0;
                end else begin
                    e_c = exp_cmd(k, cyc[k], pre_at[k]);
                    e_a = (e_c == PRE) ? 12'h400 : (e_c == MRS) ? 12'h032 : 12'h000;
                    chk("cmd", k, 32'(c_o), 32'(e_c));
                    chk("addr", k, 32'(a_o), 32'(e_a));
                    chk("busy", k, 32'(bz), 32'(!exp_done[k]));
                    chk("done", k, 32'(dn), 32'(exp_done[k]));
                    chk("done_p", k, 32'(dp), 32'(exp_done[k] && cyc[k] == done_at[k]));
                    chk("back_to_back", k, 32'(prev_nn[k] && c_o != NOP), 32'd0);
                    prev_nn[k] = (c_o != NOP);
                    if (c_o == PRE) aref_seen[k] = 0;
                    if (c_o == AREF) aref_seen[k]++;
                    if (c_o == MRS) chk("aref_count", k, 32'(aref_seen[k]), 32'(p_naref(k)));
                    if (k == 0 && pre_at[0] == 10000) begin
                        case (cyc[0])
                            10000:        chk("pin_pre", 0, 32'({c_o, a_o}), 32'({4'b0010, 12'h400}));
                            10003, 10011: chk("pin_aref", 0, 32'(c_o), 32'(4'b0001));
                            10019:        chk("pin_mrs", 0, 32'({c_o, a_o}), 32'({4'b0000, 12'h032}));
                            10021:        chk("pin_not_done", 0, 32'({bz, dn}), 32'(2'b10));
                            10022:        chk("pin_done", 0, 32'({bz, dn, dp}), 32'(3'b011));
                            default: ;
                        endcase
                    end
                    if (k == 1 && pre_at[1] == 16) begin
                        case (cyc[1])
                            19, 47:  chk("pin_aref8", 1, 32'(c_o), 32'(4'b0001));
                            51:      chk("pin_mrs8", 1, 32'(c_o), 32'(4'b0000));
                            54:      chk("pin_done8", 1, 32'({bz, dn, dp}), 32'(3'b011));
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the model's done level on config 0, optionally sprinkling ignored requests
    task automatic wait_done0(input int budget, input bit rnd);
        int n;
        n = 0;
        while (!exp_done[0]) begin
            tick();
            req0 = rnd && (cyc[0] == 10005 || $urandom_range(0, 199) == 0);
            n++;
            if (n > budget) begin
                $display("FAIL wait_done timeout after %0d cycles", n);
                $fatal(1, "bench stopped");
            end
        end
        req0 = 1'b0;
    endtask

    initial begin
        int n;
        rstn0 = 1'b0;
        req0  = 1'b0;
        repeat (3) tick();
        rstn0 = 1'b1;
        wait_done0(11000, 1'b1);
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 6)) tick();
            req0 = 1'b1;
            tick();
            req0 = 1'b0;
            wait_done0(100, 1'b0);
            $display("re-init %0d complete at cyc %0d", i, cyc[0]);
        end
        req0 = 1'b1;
        repeat (80) tick();
        req0 = 1'b0;
        wait_done0(100, 1'b0);
        rstn0 = 1'b0;
        repeat (2) tick();
        rstn0 = 1'b1;
        n = 0;
        while (cyc[0] != 10005 && n < 11000) begin
            tick();
            n++;
        end
        rstn0 = 1'b0;
        repeat (3) tick();
        rstn0 = 1'b1;
        wait_done0(11000, 1'b0);
        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rstn1 = 1'b0;
        req1  = 1'b0;
        repeat (3) tick();
        rstn1 = 1'b1;
        forever begin
            tick();
            req1 = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2999) == 0) begin
                rstn1 = 1'b0;
                tick();
                rstn1 = 1'b1;
            end
        end
    end

endmodule
